// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - Pipelined add/subtract unit, one CHUNK-bit ripple slice per stage, valid/ready stream
module pipelined_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int STAGES = WIDTH / CHUNK;

  // The whole pipe shifts together; a stalled output freezes every stage, bubbles included.
  logic enable;
  assign enable   = !out_valid || out_ready;
  assign in_ready = enable;

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    localparam int REM = WIDTH - k * CHUNK;

    logic [REM-1:0]           srcA;
    logic [REM-1:0]           srcB;
    logic                     srcCarry;
    logic                     srcValid;
    logic [CHUNK:0]           part;
    logic [(k+1)*CHUNK-1:0]   newSum;
    logic                     vldR;
    logic [(k+1)*CHUNK-1:0]   sumR;

    if (k == 0) begin : gFirst
      assign srcA     = a;
      assign srcB     = sub ? ~b : b;
      assign srcCarry = carry_in ^ sub;
      assign srcValid = in_valid;
      assign newSum   = part[CHUNK-1:0];
    end else begin : gNext
      assign srcA     = gStage[k-1].gMid.remA;
      assign srcB     = gStage[k-1].gMid.remB;
      assign srcCarry = gStage[k-1].gMid.cyR;
      assign srcValid = gStage[k-1].vldR;
      assign newSum   = {part[CHUNK-1:0], gStage[k-1].sumR};
    end

    assign part = {1'b0, srcA[CHUNK-1:0]} + {1'b0, srcB[CHUNK-1:0]} + {{CHUNK{1'b0}}, srcCarry};

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vldR <= 1'b0;
        sumR <= '0;
      end else if (enable) begin
        vldR <= srcValid;
        sumR <= newSum;
      end
    end

    // Upper operand slices still to be summed ride along with their carry.
    if (k < STAGES - 1) begin : gMid
      logic                 cyR;
      logic [REM-CHUNK-1:0] remA;
      logic [REM-CHUNK-1:0] remB;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cyR  <= 1'b0;
          remA <= '0;
          remB <= '0;
        end else if (enable) begin
          cyR  <= part[CHUNK];
          remA <= srcA[REM-1:CHUNK];
          remB <= srcB[REM-1:CHUNK];
        end
      end
    end else begin : gLast
      logic carryOutR;
      logic overflowR;
      logic zeroR;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          carryOutR <= 1'b0;
          overflowR <= 1'b0;
          zeroR     <= 1'b0;
        end else if (enable) begin
          carryOutR <= part[CHUNK];
          overflowR <= (srcA[CHUNK-1] == srcB[CHUNK-1]) && (part[CHUNK-1] != srcA[CHUNK-1]);
          zeroR     <= (newSum == '0);
        end
      end
    end
  end

  assign out_valid = gStage[STAGES-1].vldR;
  assign result    = gStage[STAGES-1].sumR;
  assign carry_out = gStage[STAGES-1].gLast.carryOutR;
  assign overflow  = gStage[STAGES-1].gLast.overflowR;
  assign zero      = gStage[STAGES-1].gLast.zeroR;

endmodule
